// File: rtl/spi_slave_frame_if.sv
// rtl/spi_slave_frame_if.sv - SPI slave frame bus bundle
//
// Groups the serial link, RAM read-data handshake and receive/error strobes
// of spi_slave_frame.
//   slave  : the frame engine (samples SS_n/MOSI/tx_*, drives MISO/rx_*/frame_err)
//   master : the SPI master + RAM wrapper side
interface spi_slave_frame_if #(
   parameter int DATA_W = 8
) ();
   logic              SS_n;
   logic              MOSI;
   logic              MISO;
   logic              tx_valid;
   logic [DATA_W-1:0] tx_data;
   logic              rx_valid;
   logic [DATA_W+1:0] rx_data;
   logic              frame_err;

   modport slave (
      input  SS_n, MOSI, tx_valid, tx_data,
      output MISO, rx_valid, rx_data, frame_err
   );

   modport master (
      output SS_n, MOSI, tx_valid, tx_data,
      input  MISO, rx_valid, rx_data, frame_err
   );
endinterface

// File: rtl/spi_slave_frame.sv
// rtl/spi_slave_frame.sv - SPI slave frame engine between SPI master and RAM
//
// Deserialises F = DATA_W+2 bit frames {cmd[1:0], payload} from MOSI into
// rx_data/rx_valid, tracks the read-address/read-data sequence via
// rd_pending, waits for RAM read data (tx_valid/tx_data) and shifts it out
// on MISO. frame_err pulses on aborted frames and on read commands whose
// cmd[0] disagrees with rd_pending.
// Ports:
//   clk    - single clock, everything sampled/updated on the rising edge
//   rst_n  - synchronous active-low reset
//   bus    - spi_slave_frame_if.slave (SS_n, MOSI, MISO, tx_valid, tx_data,
//            rx_valid, rx_data, frame_err)
module spi_slave_frame #(
   parameter int DATA_W    = 8,
   parameter int LSB_FIRST = 0
) (
   input logic              clk,
   input logic              rst_n,
   spi_slave_frame_if.slave bus
);
   localparam int F     = DATA_W + 2;
   localparam int CNT_W = $clog2(F);
   localparam logic [CNT_W-1:0] RX_LAST = CNT_W'(F - 2);
   localparam logic [CNT_W-1:0] TX_LAST = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic [2:0] {
      IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, WAIT_TX, TX, HOLD
   } state_t;

   // Maps a payload between wire order and MSB-first order; the mapping is
   // its own inverse so it serves both receive and transmit.
   function automatic logic [DATA_W-1:0] to_msb_first(input logic [DATA_W-1:0] v);
      logic [DATA_W-1:0] r;
      for (int i = 0; i < DATA_W; i++) r[i] = v[DATA_W-1-i];
      return (LSB_FIRST != 0) ? r : v;
   endfunction

   state_t            state, state_d;
   logic [CNT_W-1:0]  cnt, cnt_d;
   logic [F-2:0]      frame_sr, frame_d;
   logic [DATA_W-1:0] tx_sr, tx_d;
   logic              rd_pending, pend_d;
   logic              miso_q, miso_d;
   logic              rx_valid_q, rx_valid_d;
   logic [F-1:0]      rx_data_q, rx_data_d;
   logic              err_q, err_d;

   // Frame as it stands including the bit sampled on this edge.
   logic [F-1:0]      assembled;
   logic [DATA_W-1:0] tx_ordered;

   assign assembled  = {frame_sr, bus.MOSI};
   assign tx_ordered = to_msb_first(bus.tx_data);

   assign bus.MISO      = miso_q;
   assign bus.rx_valid  = rx_valid_q;
   assign bus.rx_data   = rx_data_q;
   assign bus.frame_err = err_q;

   always_comb begin
      state_d    = state;
      cnt_d      = cnt;
      frame_d    = frame_sr;
      tx_d       = tx_sr;
      pend_d     = rd_pending;
      miso_d     = miso_q;
      rx_valid_d = 1'b0;
      rx_data_d  = rx_data_q;
      err_d      = 1'b0;

      case (state)
         IDLE: begin
            miso_d = 1'b0;
            if (!bus.SS_n) state_d = CHK_CMD;
         end
         CHK_CMD, WRITE, READ_ADD, READ_DATA: begin
            if (bus.SS_n) begin
               state_d = IDLE;
               err_d   = 1'b1;
               miso_d  = 1'b0;
            end else begin
               frame_d = assembled[F-2:0];
               if (state == CHK_CMD) begin
                  cnt_d = '0;
                  if (!bus.MOSI)      state_d = WRITE;
                  else if (rd_pending) state_d = READ_DATA;
                  else                 state_d = READ_ADD;
               end else begin
                  cnt_d = cnt + CNT_ONE;
                  if (cnt == RX_LAST) begin
                     rx_valid_d = 1'b1;
                     rx_data_d  = {assembled[F-1:F-2], to_msb_first(assembled[DATA_W-1:0])};
                     // Read commands must carry cmd[0] equal to the pending flag;
                     // a mismatch is flagged but the frame still goes through.
                     err_d      = assembled[F-1] && (assembled[F-2] != rd_pending);
                     if (state == READ_DATA) begin
                        state_d = WAIT_TX;
                     end else begin
                        state_d = HOLD;
                        if (state == READ_ADD) pend_d = 1'b1;
                     end
                  end
               end
            end
         end
         WAIT_TX: begin
            if (bus.SS_n) begin
               state_d = IDLE;
               err_d   = 1'b1;
               miso_d  = 1'b0;
            end else if (bus.tx_valid) begin
               // First bit goes out immediately so it is on MISO the next cycle.
               miso_d  = tx_ordered[DATA_W-1];
               tx_d    = {tx_ordered[DATA_W-2:0], 1'b0};
               cnt_d   = '0;
               state_d = TX;
            end
         end
         TX: begin
            if (bus.SS_n) begin
               state_d = IDLE;
               err_d   = 1'b1;
               miso_d  = 1'b0;
            end else if (cnt == TX_LAST) begin
               miso_d  = 1'b0;
               pend_d  = 1'b0;
               state_d = HOLD;
            end else begin
               miso_d = tx_sr[DATA_W-1];
               tx_d   = {tx_sr[DATA_W-2:0], 1'b0};
               cnt_d  = cnt + CNT_ONE;
            end
         end
         HOLD: begin
            if (bus.SS_n) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         frame_sr   <= '0;
         tx_sr      <= '0;
         rd_pending <= 1'b0;
         miso_q     <= 1'b0;
         rx_valid_q <= 1'b0;
         rx_data_q  <= '0;
         err_q      <= 1'b0;
      end else begin
         state      <= state_d;
         cnt        <= cnt_d;
         frame_sr   <= frame_d;
         tx_sr      <= tx_d;
         rd_pending <= pend_d;
         miso_q     <= miso_d;
         rx_valid_q <= rx_valid_d;
         rx_data_q  <= rx_data_d;
         err_q      <= err_d;
      end
   end
endmodule

// File: tb/tb_spi_slave_frame.sv
// tb/tb_spi_slave_frame.sv - self-checking bench for spi_slave_frame
//
// Two instances (MSB-first and LSB-first) see identical wire stimulus; a
// frame-level model predicts rx_data, frame_err, MISO bits and rd_pending.
module tb_spi_slave_frame;
   localparam int W = 8;
   localparam int F = W + 2;

   logic clk = 1'b0;
   logic rst_n;
   logic ss_n, mosi, tx_valid;
   logic [W-1:0] tx_data;

   always #5 clk = ~clk;

   spi_slave_frame_if #(.DATA_W(W)) if0 ();
   spi_slave_frame_if #(.DATA_W(W)) if1 ();

   assign if0.SS_n = ss_n;     assign if1.SS_n = ss_n;
   assign if0.MOSI = mosi;     assign if1.MOSI = mosi;
   assign if0.tx_valid = tx_valid; assign if1.tx_valid = tx_valid;
   assign if0.tx_data = tx_data;   assign if1.tx_data = tx_data;

   spi_slave_frame #(.DATA_W(W), .LSB_FIRST(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
   spi_slave_frame #(.DATA_W(W), .LSB_FIRST(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

   int n_checks = 0;
   int n_pass   = 0;
   int rxv0 = 0, rxv1 = 0, err0 = 0, err1 = 0;
   int exp_rxv = 0, exp_err = 0;
   bit pend = 1'b0;

   always @(negedge clk) begin
      if (if0.rx_valid)  rxv0++;
      if (if1.rx_valid)  rxv1++;
      if (if0.frame_err) err0++;
      if (if1.frame_err) err1++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_counts();
      check("rxv_count0", rxv0, exp_rxv);
      check("rxv_count1", rxv1, exp_rxv);
      check("err_count0", err0, exp_err);
      check("err_count1", err1, exp_err);
   endtask

   // fr is sent MSB (fr[F-1]) first. abort_at: bits sent before SS_n rises
   // (-1 none). tx_stop: MISO bits seen before SS_n rises or reset (-1 none).
   task automatic do_frame(input logic [F-1:0] fr, input int abort_at,
                           input logic [W-1:0] txd, input int tx_stop, input bit tx_rst);
      bit b[F];
      logic [F-1:0] e0, e1;
      bit c1, c0, err_exp, rd_path;
      int pay1;
      for (int i = 0; i < F; i++) b[i] = fr[F-1-i];
      c1 = b[0];
      c0 = b[1];
      err_exp = c1 && (c0 != pend);
      rd_path = c1 && pend;

      ss_n = 1'b0;
      step();                                   // edge 0
      for (int i = 0; i < F; i++) begin
         if (i == abort_at) begin
            ss_n = 1'b1;
            tx_valid = 1'b0;
            step();
            exp_err++;
            check("abort_err0", if0.frame_err, 1);
            check("abort_err1", if1.frame_err, 1);
            check("abort_rxv0", if0.rx_valid, 0);
            check("abort_miso0", if0.MISO, 0);
            step();
            check_counts();
            return;
         end
         mosi = b[i];
         tx_valid = 1'($urandom_range(0, 1));   // ignored outside WAIT_TX
         step();
      end
      tx_valid = 1'b0;

      e0 = '0;
      for (int i = 0; i < F; i++) e0 = (e0 << 1) | F'(b[i]);
      pay1 = 0;
      for (int i = 0; i < W; i++) pay1 += int'(b[2+i]) << i;
      e1 = {c1, c0, W'(pay1)};

      exp_rxv++;
      if (err_exp) exp_err++;
      check("rxv0", if0.rx_valid, 1);
      check("rxv1", if1.rx_valid, 1);
      check("rx_data0", if0.rx_data, e0);
      check("rx_data1", if1.rx_data, e1);
      check("ferr0", if0.frame_err, err_exp);
      check("ferr1", if1.frame_err, err_exp);
      if (c1 && !pend) pend = 1'b1;
      step();
      check("rxv_drop0", if0.rx_valid, 0);

      if (rd_path) begin
         repeat ($urandom_range(0, 3)) step();
         check("miso_wait0", if0.MISO, 0);
         tx_valid = 1'b1;
         tx_data  = txd;
         step();                                // edge t
         tx_valid = 1'b0;
         for (int i = 0; i < W; i++) begin
            if (i == tx_stop) begin
               ss_n = 1'b1;
               if (tx_rst) rst_n = 1'b0;
               step();
               rst_n = 1'b1;
               if (tx_rst) pend = 1'b0;
               else begin
                  exp_err++;
                  check("txabort_err0", if0.frame_err, 1);
               end
               check("txstop_miso0", if0.MISO, 0);
               check("txstop_miso1", if1.MISO, 0);
               step();
               check_counts();
               return;
            end
            check("miso0", if0.MISO, txd[W-1-i]);
            check("miso1", if1.MISO, txd[i]);
            step();
         end
         check("miso_end0", if0.MISO, 0);
         check("miso_end1", if1.MISO, 0);
         pend = 1'b0;
      end

      // Extra clocks in HOLD must not start another frame.
      repeat ($urandom_range(0, 3)) begin
         mosi = 1'($urandom_range(0, 1));
         tx_valid = 1'($urandom_range(0, 1));
         step();
      end
      tx_valid = 1'b0;
      ss_n = 1'b1;
      repeat ($urandom_range(1, 2)) step();
      check_counts();
   endtask

   initial begin
      rst_n = 1'b0; ss_n = 1'b1; mosi = 1'b0; tx_valid = 1'b0; tx_data = '0;
      repeat (3) step();
      check("rst_miso0", if0.MISO, 0);
      check("rst_rxv0", if0.rx_valid, 0);
      check("rst_rxdata0", if0.rx_data, 0);
      check("rst_err0", if0.frame_err, 0);
      check("rst_rxdata1", if1.rx_data, 0);
      rst_n = 1'b1;
      step();

      do_frame(10'h0A5, -1, 8'h00, -1, 0);     // write address
      do_frame(10'h23C, -1, 8'h00, -1, 0);     // read address
      do_frame(10'h300, -1, 8'hC3, -1, 0);     // read data
      do_frame(10'h0AA,  5, 8'h00, -1, 0);     // aborted write
      do_frame(10'h1FF, -1, 8'h00, -1, 0);
      do_frame(10'h23C, -1, 8'h00, -1, 0);
      do_frame(10'h200, -1, 8'h5A, -1, 0);     // cmd 10 while pending
      do_frame(10'h255, -1, 8'h00, -1, 0);
      do_frame(10'h380, -1, 8'h80, -1, 0);     // LSB-first sees payload 01
      do_frame(10'h211, -1, 8'h00, -1, 0);
      do_frame(10'h300, -1, 8'hE7,  3, 1);     // reset mid-TX
      do_frame(10'h377, -1, 8'h00, -1, 0);     // goes to READ_ADD after reset
      do_frame(10'h300, -1, 8'h69,  5, 0);     // TX abort keeps pending
      do_frame(10'h300, -1, 8'h96, -1, 0);     // retry succeeds

      for (int k = 0; k < 40; k++) begin
         logic [F-1:0] fr;
         int ab, ts;
         fr = F'($urandom);
         ab = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, F-1)) : -1;
         ts = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, W-1)) : -1;
         do_frame(fr, ab, W'($urandom), ts, 1'($urandom_range(0, 1)));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
